// File: rtl/rv32_dma_pkg.sv
// Shared types and constants for the rv32 DMA master: FSM encoding, mode and strobe values.
package rv32_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StGap,
    StWr,
    StDone
  } dma_state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [3:0] WSTRB_READ = 4'b0000;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  localparam logic [31:0] WORD_STEP = 32'd4;

  // The bus only ever carries whole words, so the low address bits are dropped at latch time.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_dma_master_if.sv
// picorv32 native memory bus as seen between the DMA initiator and the address decoder.
interface rv32_dma_master_if;

  logic        rv32_valid;
  logic        rv32_ready;
  logic [31:0] rv32_addr;
  logic [31:0] rv32_wdata;
  logic [3:0]  rv32_wstrb;
  logic [31:0] rv32_rdata;

  modport master (
    output rv32_valid,
    output rv32_addr,
    output rv32_wdata,
    output rv32_wstrb,
    input  rv32_ready,
    input  rv32_rdata
  );

  modport slave (
    input  rv32_valid,
    input  rv32_addr,
    input  rv32_wdata,
    input  rv32_wstrb,
    output rv32_ready,
    output rv32_rdata
  );

endinterface

// File: rtl/bus_watchdog.sv
// Counts stalled request cycles and flags expiry on the TIMEOUT_CYCLES-th one; 0 disables it.
module bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic Enabled = (TIMEOUT_CYCLES != 0);

  logic [CntW-1:0] count_q, count_d;

  // Saturate at the last value so a disabled or long-stalled counter never wraps.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (stall && (count_q != CntLast)) begin
      count_d = count_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    expired = Enabled && stall && !clear && (count_q == CntLast);
  end

endmodule

// File: rtl/rv32_dma_master.sv
// Block-copy / block-fill initiator on the picorv32 native bus; one word per request, one idle
// cycle between requests, optional watchdog abort on a responder that never answers.
module rv32_dma_master
  import rv32_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 cfg_mode,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic [31:0]          cfg_fill,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  rv32_dma_master_if.master    bus
);

  dma_state_e           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [LEN_WIDTH-1:0] remain_q, remain_d;
  logic [31:0]          data_q, data_d;
  logic [31:0]          fill_q, fill_d;
  logic                 error_q, error_d;
  // Set once a COPY read has landed in data_q and its write is still owed.
  logic                 pending_q, pending_d;

  logic                 req_active;
  logic                 stall;
  logic                 expired;
  logic                 valid;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [3:0]           wstrb;

  assign stall = req_active && !bus.rv32_ready;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clear  (!req_active),
    .stall  (stall),
    .expired(expired)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    src_d     = src_q;
    dst_d     = dst_q;
    remain_d  = remain_q;
    data_d    = data_q;
    fill_d    = fill_q;
    error_d   = error_q;
    pending_d = pending_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = cfg_mode;
          src_d     = word_align(cfg_src);
          dst_d     = word_align(cfg_dst);
          remain_d  = cfg_len;
          fill_d    = cfg_fill;
          error_d   = 1'b0;
          pending_d = 1'b0;
          if (cfg_len == '0) begin
            state_d = StDone;
          end else if (cfg_mode == MODE_FILL) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end

      StRd: begin
        if (bus.rv32_ready) begin
          data_d    = bus.rv32_rdata;
          pending_d = 1'b1;
          state_d   = StGap;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end

      StWr: begin
        if (bus.rv32_ready) begin
          src_d     = src_q + WORD_STEP;
          dst_d     = dst_q + WORD_STEP;
          remain_d  = remain_q - LEN_WIDTH'(1);
          pending_d = 1'b0;
          state_d   = (remain_q == LEN_WIDTH'(1)) ? StDone : StGap;
        end else if (expired) begin
          error_d = 1'b1;
          state_d = StDone;
        end
      end

      StGap: begin
        state_d = ((mode_q == MODE_COPY) && !pending_q) ? StRd : StWr;
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      mode_q    <= MODE_COPY;
      src_q     <= '0;
      dst_q     <= '0;
      remain_q  <= '0;
      data_q    <= '0;
      fill_q    <= '0;
      error_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      remain_q  <= remain_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      error_q   <= error_d;
      pending_q <= pending_d;
    end
  end

  // Bus outputs decode purely from registered state, so they are stable for a whole request.
  always_comb begin
    req_active = (state_q == StRd) || (state_q == StWr);
    valid      = req_active;
    addr       = '0;
    wdata      = '0;
    wstrb      = WSTRB_READ;
    if (state_q == StRd) begin
      addr = src_q;
    end else if (state_q == StWr) begin
      addr  = dst_q;
      wstrb = WSTRB_WORD;
      wdata = (mode_q == MODE_FILL) ? fill_q : data_q;
    end
  end

  assign bus.rv32_valid = valid;
  assign bus.rv32_addr  = addr;
  assign bus.rv32_wdata = wdata;
  assign bus.rv32_wstrb = wstrb;

  assign busy  = (state_q != StIdle);
  assign done  = (state_q == StDone);
  assign error = error_q;

  a_hold_while_stalled: assert property (
    @(posedge clk) disable iff (reset)
    (valid && !bus.rv32_ready) |=> (!valid || ($stable(addr) && $stable(wdata) && $stable(wstrb)))
  );

  a_gap_after_complete: assert property (
    @(posedge clk) disable iff (reset)
    (valid && bus.rv32_ready) |=> !valid
  );

endmodule

// File: tb/tb_rv32_dma_master.sv
// Self-checking bench: memory responder, bus monitor, transfer model, table + random + corner cases.
module tb_rv32_dma_master;
  import rv32_dma_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          beg;
    int          fin;
  } txn_t;

  typedef struct {
    logic        mode;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] fill;
    int          dly;
    int          exp_done;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [31:0] cfg_src = '0;
  logic [31:0] cfg_dst = '0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_fill = '0;
  logic        busy, done, error;

  rv32_dma_master_if bus ();

  rv32_dma_master #(
    .LEN_WIDTH     (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .cfg_mode(cfg_mode),
    .cfg_src (cfg_src),
    .cfg_dst (cfg_dst),
    .cfg_len (cfg_len),
    .cfg_fill(cfg_fill),
    .busy    (busy),
    .done    (done),
    .error   (error),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Responder: word memory indexed by addr[11:2], fixed wait states, optional never-ready.
  logic [31:0] mem [1024];
  logic [31:0] model_mem [1024];
  int          resp_delay = 0;
  bit          never_ready = 1'b0;
  int          wait_q = 0;

  assign bus.rv32_ready = bus.rv32_valid && !never_ready && (wait_q == resp_delay);
  assign bus.rv32_rdata = bus.rv32_ready ? mem[bus.rv32_addr[11:2]] : 32'h0;

  always @(posedge clk) begin
    if (!bus.rv32_valid || bus.rv32_ready) wait_q <= 0;
    else wait_q <= wait_q + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor, sampled mid-cycle.
  txn_t log_q[$];
  txn_t exp_q[$];
  txn_t cur;
  logic in_req = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   stab_err = 0;
  int   valid_cyc = 0;

  always @(negedge clk) begin
    if (bus.rv32_valid) begin
      valid_cyc++;
      if (!in_req) begin
        in_req    = 1'b1;
        cur.addr  = bus.rv32_addr;
        cur.wdata = bus.rv32_wdata;
        cur.wstrb = bus.rv32_wstrb;
        cur.beg   = cyc;
        cur.fin   = 0;
      end else if (bus.rv32_addr !== cur.addr || bus.rv32_wdata !== cur.wdata ||
                   bus.rv32_wstrb !== cur.wstrb) begin
        stab_err++;
      end
      if (bus.rv32_ready) begin
        cur.fin = cyc;
        log_q.push_back(cur);
        in_req = 1'b0;
        if (bus.rv32_wstrb == 4'hF) mem[bus.rv32_addr[11:2]] = bus.rv32_wdata;
      end
    end else begin
      in_req = 1'b0;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // Reference: words move one at a time in order, so later reads see earlier writes.
  task automatic build_expected(input logic m, input logic [31:0] s_in, input logic [31:0] d_in,
                                input logic [15:0] l, input logic [31:0] f);
    logic [31:0] s, d, v;
    txn_t t;
    exp_q.delete();
    model_mem = mem;
    s = s_in & 32'hFFFF_FFFC;
    d = d_in & 32'hFFFF_FFFC;
    for (int i = 0; i < int'(l); i++) begin
      t = '{default: 0};
      if (m == MODE_COPY) begin
        t.addr  = s;
        t.wstrb = 4'h0;
        exp_q.push_back(t);
        v = model_mem[s[11:2]];
      end else begin
        v = f;
      end
      t.addr  = d;
      t.wdata = v;
      t.wstrb = 4'hF;
      exp_q.push_back(t);
      model_mem[d[11:2]] = v;
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  // Returns in cycle T+1, T being the cycle start was high.
  task automatic begin_xfer(input logic m, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] l, input logic [31:0] f, output int t0);
    log_q.delete();
    done_cnt  = 0;
    done_cyc  = -1;
    stab_err  = 0;
    valid_cyc = 0;
    build_expected(m, s, d, l, f);
    @(posedge clk);
    #1;
    cfg_mode = m;
    cfg_src  = s;
    cfg_dst  = d;
    cfg_len  = l;
    cfg_fill = f;
    start    = 1'b1;
    t0       = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int t0, input int exp_done,
                             input logic exp_err, input bit cmp_log);
    int k, bad, n;
    sample();
    chk({tag, " busy_on"}, 32'(busy), 32'd1);
    k = 0;
    while (done_cnt == 0 && k < 4000) begin
      sample();
      k++;
    end
    chk({tag, " done_seen"}, done_cnt, 32'd1);
    chk({tag, " done_lat"}, done_cyc - t0, exp_done);
    chk({tag, " error"}, 32'(error), 32'(exp_err));
    sample();
    chk({tag, " busy_off"}, 32'(busy), 32'd0);
    repeat (3) sample();
    chk({tag, " done_once"}, done_cnt, 32'd1);
    chk({tag, " stable"}, stab_err, 32'd0);
    if (cmp_log) begin
      chk({tag, " txn_count"}, log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
        chk($sformatf("%s addr%0d", tag, i), log_q[i].addr, exp_q[i].addr);
        chk($sformatf("%s wstrb%0d", tag, i), 32'(log_q[i].wstrb), 32'(exp_q[i].wstrb));
        if (exp_q[i].wstrb == 4'hF)
          chk($sformatf("%s wdata%0d", tag, i), log_q[i].wdata, exp_q[i].wdata);
      end
      bad = 0;
      if (log_q.size() > 0 && log_q[0].beg != t0 + 1) bad++;
      for (int i = 1; i < log_q.size(); i++) begin
        if (log_q[i].beg != log_q[i-1].fin + 2) bad++;
      end
      chk({tag, " gap"}, bad, 32'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vecs[6];
    int   t0, n;
    logic m;
    logic [15:0] l;

    vecs[0] = '{MODE_COPY, 32'h0000_0100, 32'h0000_0200, 16'd4, 32'h0, 0, 16};
    vecs[1] = '{MODE_FILL, 32'h0000_0000, 32'h0000_0040, 16'd3, 32'hDEAD_BEEF, 0, 6};
    vecs[2] = '{MODE_COPY, 32'h0000_0120, 32'h0000_0220, 16'd2, 32'h0, 3, 20};
    vecs[3] = '{MODE_COPY, 32'h0000_0130, 32'h0000_0230, 16'd0, 32'h0, 0, 1};
    vecs[4] = '{MODE_FILL, 32'h0000_0000, 32'hFFFF_FFFC, 16'd2, 32'h1234_5678, 0, 4};
    vecs[5] = '{MODE_COPY, 32'h0000_0103, 32'h0000_0300, 16'd1, 32'h0, 0, 4};

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = 32'h1111_1111 * (i + 1);

    // Reset values, and start coinciding with reset is dropped.
    repeat (3) @(posedge clk);
    sample();
    chk("rst valid", 32'(bus.rv32_valid), 32'd0);
    chk("rst addr", bus.rv32_addr, 32'd0);
    chk("rst wdata", bus.rv32_wdata, 32'd0);
    chk("rst wstrb", 32'(bus.rv32_wstrb), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst error", 32'(error), 32'd0);
    @(posedge clk);
    #1;
    cfg_len = 16'd3;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    reset = 1'b0;
    sample();
    chk("rst_start busy", 32'(busy), 32'd0);
    chk("rst_start valid", 32'(bus.rv32_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      resp_delay = vecs[i].dly;
      begin_xfer(vecs[i].mode, vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].fill, t0);
      finish_xfer($sformatf("vec%0d", i), t0, vecs[i].exp_done, 1'b0, 1'b1);
      if (vecs[i].len == 16'd0) chk("len0 no_valid", valid_cyc, 32'd0);
    end

    // Watchdog abort on a dead responder, then the next start clears error.
    never_ready = 1'b1;
    resp_delay  = 0;
    begin_xfer(MODE_COPY, 32'h500, 32'h580, 16'd5, 32'h0, t0);
    finish_xfer("timeout", t0, 9, 1'b1, 1'b0);
    chk("timeout no_txn", log_q.size(), 32'd0);
    chk("timeout valid_cycles", valid_cyc, 32'd8);
    chk("timeout sticky", 32'(error), 32'd1);
    never_ready = 1'b0;
    begin_xfer(MODE_FILL, 32'h0, 32'h600, 16'd1, 32'hA5A5_0001, t0);
    finish_xfer("post_timeout", t0, 2, 1'b0, 1'b1);

    // Start pulses while busy must not disturb the running transfer.
    resp_delay = 1;
    begin_xfer(MODE_FILL, 32'h0, 32'h700, 16'd3, 32'hCAFE_F00D, t0);
    cfg_mode = MODE_COPY;
    cfg_src  = 32'h800;
    cfg_dst  = 32'h880;
    cfg_len  = 16'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_xfer("busy_start", t0, 9, 1'b0, 1'b1);

    // Reset while a stalled read is on the bus.
    resp_delay = 3;
    begin_xfer(MODE_COPY, 32'h100, 32'h900, 16'd4, 32'h0, t0);
    sample();
    chk("midrst valid_pre", 32'(bus.rv32_valid), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    sample();
    chk("midrst valid", 32'(bus.rv32_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    repeat (20) sample();
    chk("midrst no_done", done_cnt, 32'd0);
    chk("midrst no_txn", log_q.size(), 32'd0);
    chk("midrst valid_cycles", valid_cyc, 32'd2);

    // Randomised transfers against the model.
    for (int it = 0; it < 16; it++) begin
      m          = 1'($urandom_range(0, 1));
      l          = 16'($urandom_range(1, 10));
      resp_delay = int'($urandom_range(0, 3));
      n          = (m == MODE_COPY) ? 2 * int'(l) : int'(l);
      begin_xfer(m, ($urandom_range(0, 255) << 2) | $urandom_range(0, 3),
                 ($urandom_range(0, 255) << 2) | $urandom_range(0, 3), l, $urandom, t0);
      finish_xfer($sformatf("rnd%0d", it), t0, n * (resp_delay + 2), 1'b0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
